// File: rtl/sha256_compress_iter.sv
// Iterative SHA-256 compression: one 512-bit block per request, ROUNDS_PER_CYCLE
// rounds per clock over a rolling 16-word schedule window.
module sha256_compress_iter #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  input  logic         i_start,
  input  logic         i_init,
  input  logic [255:0] i_hin,
  input  logic [511:0] i_block,
  output logic         o_ready,
  output logic         o_valid,
  output logic [255:0] o_digest
);

  localparam int R     = ROUNDS_PER_CYCLE;
  localparam int ITERS = 64 / ROUNDS_PER_CYCLE;

  generate
    if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
      $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_e;

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Working state packed with A in element 0 through H in element 7.
  function automatic logic [7:0][31:0] sha_round(input logic [7:0][31:0] s,
                                                 input logic [31:0] k,
                                                 input logic [31:0] w);
    logic [31:0]      t1, t2;
    logic [7:0][31:0] n;
    t1   = s[7] + bsig1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
    t2   = bsig0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    n[0] = t1 + t2;
    n[1] = s[0];
    n[2] = s[1];
    n[3] = s[2];
    n[4] = s[3] + t1;
    n[5] = s[4];
    n[6] = s[5];
    n[7] = s[6];
    return n;
  endfunction

  state_e            state_q;
  logic [5:0]        t_q;
  logic [7:0][31:0]  wk_q, chain_q;
  logic [15:0][31:0] w_q;
  logic              o_ready_q, o_valid_q;
  logic [255:0]      o_digest_q;

  logic [31:0]       ext [16+R];
  logic [7:0][31:0]  rs  [R+1];
  logic [15:0][31:0] w_d;
  logic [15:0][31:0] blk_w;
  logic [7:0][31:0]  h_sel;
  logic [255:0]      dig_sum;

  // w_q[0] always holds W[t]; the R words beyond the window are expanded
  // here so the window can slide by R each cycle.
  always_comb begin
    for (int j = 0; j < 16 + R; j++) ext[j] = '0;
    for (int j = 0; j < 16; j++) ext[j] = w_q[j];
    for (int j = 16; j < 16 + R; j++)
      ext[j] = ssig1(ext[j-2]) + ext[j-7] + ssig0(ext[j-15]) + ext[j-16];
    w_d = '0;
    for (int j = 0; j < 16; j++) w_d[j] = ext[j+R];
  end

  always_comb begin
    for (int r = 0; r <= R; r++) rs[r] = '0;
    rs[0] = wk_q;
    for (int r = 0; r < R; r++)
      rs[r+1] = sha_round(rs[r], K_ROM[t_q + 6'(r)], ext[r]);
  end

  always_comb begin
    blk_w   = '0;
    h_sel   = '0;
    dig_sum = '0;
    for (int j = 0; j < 16; j++) blk_w[j] = i_block[511-32*j -: 32];
    for (int i = 0; i < 8; i++) begin
      h_sel[i]                 = i_init ? IV[255-32*i -: 32] : i_hin[255-32*i -: 32];
      dig_sum[255-32*i -: 32]  = chain_q[i] + wk_q[i];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= S_IDLE;
      t_q        <= '0;
      wk_q       <= '0;
      chain_q    <= '0;
      w_q        <= '0;
      o_ready_q  <= 1'b1;
      o_valid_q  <= 1'b0;
      o_digest_q <= '0;
    end else begin
      o_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            w_q       <= blk_w;
            chain_q   <= h_sel;
            wk_q      <= h_sel;
            t_q       <= '0;
            o_ready_q <= 1'b0;
            state_q   <= S_ROUND;
          end
        end
        S_ROUND: begin
          wk_q <= rs[R];
          w_q  <= w_d;
          t_q  <= t_q + 6'(R);
          if (t_q == 6'((ITERS - 1) * R)) state_q <= S_FINAL;
        end
        S_FINAL: begin
          o_digest_q <= dig_sum;
          o_valid_q  <= 1'b1;
          o_ready_q  <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_ready  = o_ready_q;
  assign o_valid  = o_valid_q;
  assign o_digest = o_digest_q;

endmodule

// File: tb/tb_sha256_compress_iter.sv
// Scoreboard bench for sha256_compress_iter: four instances (R = 1, 2, 4, 8)
// checked against a plain-loop SHA-256 reference and published digests.
module tb_sha256_compress_iter;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_MB1   = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_MB2   = {480'h0, 32'h000001c0};
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] DIG_2B    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  typedef struct {
    logic [255:0] dig;
    int           acc;
  } exp_t;

  logic              ACLK;
  logic [3:0]        rstn, st, ini, rdy, vld;
  logic [3:0][255:0] hin, dig;
  logic [3:0][511:0] blk;

  logic              kat_en [4];
  logic [255:0]      kat    [4];
  exp_t              sb     [4][$];
  int                free_at [4];
  int                acc_cnt [4];
  logic [255:0]      hold   [4];
  exp_t              ev;
  int                cyc = 0;
  int                n_tests = 0;
  int                n_fail = 0;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    sha256_compress_iter #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .ACLK     (ACLK),
      .ARESETN  (rstn[g]),
      .i_start  (st[g]),
      .i_init   (ini[g]),
      .i_hin    (hin[g]),
      .i_block  (blk[g]),
      .o_ready  (rdy[g]),
      .o_valid  (vld[g]),
      .o_digest (dig[g])
    );
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: full 64-word schedule, then 64 rounds.
  function automatic logic [255:0] sha_ref(input logic [255:0] h_in, input logic [511:0] b);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
             + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    for (int i = 0; i < 8; i++) v[i] = h_in[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[i] + w[i];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    res = '0;
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = h_in[255-32*i -: 32] + v[i];
    return res;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic chk(input string nm, input int l, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL lane%0d %s at cycle %0d: got %h expected %h", l, nm, cyc, got, exp);
    end
  endtask

  // Accept model + monitor: acceptance is predicted from the bench's own
  // busy window, then outputs are compared 1 time unit after the edge.
  always @(posedge ACLK) begin
    cyc++;
    for (int l = 0; l < 4; l++) begin
      if (!rstn[l]) begin
        sb[l].delete();
        free_at[l] = 0;
        hold[l]    = '0;
      end else if (st[l] && cyc >= free_at[l]) begin
        ev.dig = kat_en[l] ? kat[l] : sha_ref(ini[l] ? IV : hin[l], blk[l]);
        ev.acc = cyc;
        sb[l].push_back(ev);
        free_at[l] = cyc + (64 >> l) + 2;
        acc_cnt[l]++;
      end
    end
    #1;
    for (int l = 0; l < 4; l++) begin
      logic exp_v;
      chk("ready", l, 256'(rdy[l]), 256'(!rstn[l] || (cyc + 1 >= free_at[l])));
      exp_v = (sb[l].size() != 0) && (cyc - sb[l][0].acc == (64 >> l) + 1);
      chk("valid", l, 256'(vld[l]), 256'(exp_v));
      if (exp_v) begin
        ev = sb[l].pop_front();
        chk("digest", l, dig[l], ev.dig);
        hold[l] = ev.dig;
      end else begin
        chk("digest_hold", l, dig[l], hold[l]);
      end
    end
  end

  task automatic issue(input int l, input logic init, input logic [255:0] h, input logic [511:0] b,
                       input logic use_kat, input logic [255:0] kv, input logic keep);
    int n;
    @(negedge ACLK);
    n = acc_cnt[l];
    ini[l] = init; hin[l] = h; blk[l] = b; kat_en[l] = use_kat; kat[l] = kv; st[l] = 1'b1;
    for (int i = 0; i < 300 && acc_cnt[l] == n; i++) @(negedge ACLK);
    // Scramble inputs right after accept; the result must not depend on them.
    st[l] = keep; hin[l] = rnd256(); blk[l] = rnd512(); ini[l] = 1'($urandom()); kat_en[l] = 1'b0;
  endtask

  task automatic drain(input int l);
    for (int i = 0; i < 300 && sb[l].size() != 0; i++) @(negedge ACLK);
    repeat (2) @(negedge ACLK);
  endtask

  initial begin
    logic [255:0] h1;
    int           n0;
    rstn = '1; st = '0; ini = '0; hin = '0; blk = '0;
    for (int l = 0; l < 4; l++) begin
      kat_en[l] = 1'b0; kat[l] = '0; free_at[l] = 0; acc_cnt[l] = 0; hold[l] = '0;
    end
    #2 rstn = '0;
    repeat (3) @(negedge ACLK);
    rstn = '1;
    fork
      begin
        issue(0, 1'b1, rnd256(), BLK_ABC, 1'b1, DIG_ABC, 1'b0);
        drain(0);
        issue(0, 1'b1, rnd256(), BLK_EMPTY, 1'b1, DIG_EMPTY, 1'b0);
        drain(0);
        h1 = sha_ref(IV, BLK_MB1);
        issue(0, 1'b1, rnd256(), BLK_MB1, 1'b0, '0, 1'b0);
        drain(0);
        issue(0, 1'b0, h1, BLK_MB2, 1'b1, DIG_2B, 1'b0);
        drain(0);
        for (int k = 0; k < 3; k++)
          issue(0, 1'($urandom()), rnd256(), rnd512(), 1'b0, '0, k < 2);
        drain(0);
        // Abort mid-computation, re-issue while still in reset.
        issue(0, 1'b1, rnd256(), BLK_ABC, 1'b1, DIG_ABC, 1'b0);
        repeat (30) @(negedge ACLK);
        n0 = acc_cnt[0];
        rstn[0] = 1'b0; ini[0] = 1'b1; blk[0] = BLK_ABC; kat_en[0] = 1'b1; kat[0] = DIG_ABC; st[0] = 1'b1;
        @(negedge ACLK);
        rstn[0] = 1'b1;
        for (int i = 0; i < 300 && acc_cnt[0] == n0; i++) @(negedge ACLK);
        st[0] = 1'b0; kat_en[0] = 1'b0;
        drain(0);
        issue(0, 1'b1, rnd256(), rnd512(), 1'b0, '0, 1'b0);
        repeat (5) @(negedge ACLK);
        st[0] = 1'b1; blk[0] = rnd512();
        @(negedge ACLK);
        st[0] = 1'b0;
        drain(0);
        for (int k = 0; k < 5; k++) begin
          issue(0, 1'($urandom()), rnd256(), rnd512(), 1'b0, '0, 1'b0);
          drain(0);
        end
      end
      begin
        for (int l = 1; l < 4; l++) begin
          issue(l, 1'b1, rnd256(), BLK_EMPTY, 1'b1, DIG_EMPTY, 1'b0);
          drain(l);
          for (int k = 0; k < 3; k++)
            issue(l, 1'($urandom()), rnd256(), rnd512(), 1'b0, '0, k < 2);
          drain(l);
        end
      end
    join
    repeat (5) @(negedge ACLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
